// File: rtl/multi_control_fsm.sv
// Multicycle RV32I control unit: Moore FSM stepping the shared datapath through
// fetch/decode/execute/memory/write-back with a bounded memory wait and sticky traps.
module multi_control_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] Instruction,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCSource,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] AuipcLui,
    output logic [3:0] State,
    output logic       IllegalOp,
    output logic       BusError
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_UPPER    = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Count value seen on the WAIT_MAX-th unacknowledged cycle of an access.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic       mem_wait;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_d    = wait_q;
        mem_wait  = 1'b0;
        PCWrite   = 1'b0;
        Branch    = 1'b0;
        PCSource  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 3'b100;
        AuipcLui  = 2'b10;

        unique case (state_q)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcA  = 2'b11;
                ALUSrcB  = 2'b01;
                IRWrite  = MemReady;
                PCWrite  = MemReady;
                mem_wait = 1'b1;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b00;
                ALUSrcB = 2'b10;
                unique case (Instruction)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_AUIPC, OP_LUI:   state_d = S_UPPER;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b00;
                ALUOp   = 3'b000;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b001;
                state_d = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b011;
                state_d = (Instruction == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                mem_wait = 1'b1;
                if (MemReady) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                mem_wait = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b00;
                ALUOp    = 3'b010;
                Branch   = 1'b1;
                PCSource = 1'b1;
                state_d  = S_FETCH;
            end
            S_UPPER: begin
                ALUSrcB = 2'b10;
                ALUOp   = 3'b100;
                if (Instruction == OP_LUI) begin
                    ALUSrcA  = 2'b10;
                    AuipcLui = 2'b01;
                end else begin
                    ALUSrcA  = 2'b00;
                    AuipcLui = 2'b00;
                end
                state_d = S_WB_ALU;
            end
            default: state_d = S_TRAP;
        endcase

        // An acknowledge on the last allowed cycle still wins over the timeout.
        if (mem_wait && !MemReady) begin
            if (wait_q == WAIT_LAST) begin
                state_d   = S_TRAP;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
        if (state_d != state_q) wait_d = '0;

        // Reset aborts any in-flight access immediately, not at the next edge.
        if (RESET) begin
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            PCSource = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 2'b00;
            ALUSrcB  = 2'b00;
            ALUOp    = 3'b100;
            AuipcLui = 2'b10;
        end
    end

    assign State     = state_q;
    assign IllegalOp = illegal_q;
    assign BusError  = bus_err_q;

endmodule

// File: doc/multi_control_fsm.md
# multi_control_fsm

Multicycle control unit for the RV32I core. It replaces the single-cycle opcode decoder with a Moore state machine that steps the shared datapath (one ALU, one unified memory port, IR/OldPC/ALUOut latches) through fetch, decode, execute, memory and write-back. It handshakes with a variable-latency memory via `MemReady`, enforces a bounded wait, and traps on illegal opcodes or memory timeout.

## Interface
- `WAIT_MAX`, 15: max cycles a memory request may stay unacknowledged before trapping (1..255).
- `CLK`  in  1  clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `Instruction`  in  7  opcode field from IR (IR[6:0]), valid from DECODE onward.
- `MemReady`  in  1  memory acknowledges the current MemRead/MemWrite this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `Branch`  out  1  conditional PC load, qualified by ALU zero in the datapath.
- `PCSource`  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  latch IR and OldPC.
- `MemRead`, `MemWrite`  out  1 each  memory request strobes.
- `MemtoReg`  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  2  00 OldPC, 01 rs1, 10 zero, 11 PC.
- `ALUSrcB`  out  2  00 rs2, 01 constant 4, 10 immediate.
- `ALUOp`  out  3  000 R, 001 I, 010 branch compare, 011 address add, 100 plain add.
- `AuipcLui`  out  2  00 auipc, 01 lui, 10 otherwise.
- `State`  out  4  current state encoding, for debug.
- `IllegalOp`, `BusError`  out  1 each  sticky trap flags.

## Operation
- States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_MEM 7, WB_ALU 8, BRANCH 9, UPPER 10, TRAP 11.
- Defaults: all strobes 0, `ALUSrcA`=00, `ALUSrcB`=00, `ALUOp`=100, `AuipcLui`=10, `PCSource`=0, `IorD`=0.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=11, `ALUSrcB`=01. `IRWrite`=`PCWrite`=`MemReady` (Mealy). Exit to DECODE on `MemReady`.
- DECODE: `ALUSrcA`=00, `ALUSrcB`=10 (branch target into ALUOut). Next by opcode: 0110011 EXEC_R; 0010011 EXEC_I; 0000011/0100011 MEM_ADDR; 1100011 BRANCH; 0010111/0110111 UPPER; other TRAP with `IllegalOp`.
- EXEC_R: A=01, B=00, ALUOp 000 -> WB_ALU. EXEC_I: A=01, B=10, ALUOp 001 -> WB_ALU.
- MEM_ADDR: A=01, B=10, ALUOp 011 -> MEM_RD if opcode 0000011, else MEM_WR.
- MEM_RD: `MemRead`=1, `IorD`=1; on `MemReady` -> WB_MEM. MEM_WR: `MemWrite`=1, `IorD`=1; on `MemReady` -> FETCH.
- WB_MEM: `RegWrite`=1, `MemtoReg`=1 -> FETCH. WB_ALU: `RegWrite`=1 -> FETCH.
- BRANCH: A=01, B=00, ALUOp 010, `Branch`=1, `PCSource`=1 -> FETCH.
- UPPER: B=10, ALUOp 100; auipc A=00, `AuipcLui`=00; lui A=10, `AuipcLui`=01 -> WB_ALU.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR, increments each cycle `MemReady`=0 there; if it reaches `WAIT_MAX` without `MemReady`, go TRAP, set `BusError`. `MemReady` on the `WAIT_MAX`th cycle wins (no trap).
- TRAP: all strobes 0; held until `RESET`. `MemReady` ignored outside FETCH/MEM_RD/MEM_WR.

## Timing
- `RESET` asserted: immediately State=FETCH, counter=0, `IllegalOp`=`BusError`=0; all strobes including `IRWrite`/`PCWrite` forced 0 while `RESET`=1; other outputs at defaults.
- First fetch request asserted the cycle after `RESET` deasserts.
- Outputs combinational from state (plus `MemReady` for `IRWrite`/`PCWrite`); state updates on rising `CLK`.
- Minimum cycles with zero-wait memory: R/I/auipc/lui 4, load 5, store 4, branch 3; each memory stall adds one cycle.
- Reset mid-access: `MemRead`/`MemWrite` drop asynchronously; memory treats request as aborted.

## Test plan
- Reset during MEM_WR with `MemReady`=0 -> `MemWrite` falls same cycle, State=0, both flags 0.
- R-type 0110011, `MemReady` held 1 -> states 0,1,2,8,0; `RegWrite`=1 only in state 8; `IRWrite` pulses once.
- Load 0000011, `MemReady` low 3 cycles in MEM_RD -> 8 cycles total; `MemtoReg`=`RegWrite`=1 in state 7.
- Branch 1100011 -> 3 cycles; state 9 drives `Branch`=1, `PCSource`=1, `ALUOp`=010.
- Lui 0110111 -> UPPER with `ALUSrcA`=10, `AuipcLui`=01, then WB_ALU; auipc gives 00/00.
- Opcode 1111111 -> TRAP, `IllegalOp`=1 held; `MemReady`=0 for 15 cycles in FETCH -> TRAP, `BusError`=1; `MemReady` on cycle 15 -> DECODE.
